// File: rtl/adder_test_pkg.sv
// Shared types and defaults for the adder self-test checker.
// Holds the FSM encoding, the latency ceiling and the default widths.
package adder_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LAT_MAX   = 4;
    localparam int DEF_W     = 8;
    localparam int DEF_CNT_W = 16;

    function automatic logic is_busy(input state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/adder_checker_if.sv
// Bundle of stimulus, adder response and result signals seen by the checker.
// master drives operands and the adder response; slave is the checker itself.
interface adder_checker_if
    import adder_test_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic             valid;
    logic             last;
    logic [W-1:0]     inA;
    logic [W-1:0]     inB;
    logic [W:0]       dutOut;
    logic             dutIsOdd;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] checkCount;
    logic [CNT_W-1:0] errCount;
    logic [W-1:0]     firstErrA;
    logic [W-1:0]     firstErrB;
    logic [W:0]       firstErrGot;
    logic [W:0]       firstErrExp;

    modport master (
        output start, valid, last, inA, inB, dutOut, dutIsOdd,
        input  busy, done, pass, checkCount, errCount,
               firstErrA, firstErrB, firstErrGot, firstErrExp
    );

    modport slave (
        input  start, valid, last, inA, inB, dutOut, dutIsOdd,
        output busy, done, pass, checkCount, errCount,
               firstErrA, firstErrB, firstErrGot, firstErrExp
    );
endinterface

// File: rtl/adder_checker_delay.sv
// LAT-stage shift register carrying a valid flag plus payload.
// A synchronous flush drops every in-flight entry; o_any_valid reports occupancy.
module adder_checker_delay #(
    parameter int LAT = 1,
    parameter int PW  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_valid,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    output logic [PW-1:0] o_data,
    output logic          o_any_valid
);
    logic [LAT-1:0] w_vld_all;
    logic [PW-1:0]  w_data_all [LAT];

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            logic          w_vld_in;
            logic [PW-1:0] w_data_in;
            logic          r_vld;
            logic [PW-1:0] r_data;

            if (gi == 0) begin : g_head
                assign w_vld_in  = i_valid;
                assign w_data_in = i_data;
            end else begin : g_body
                assign w_vld_in  = w_vld_all[gi-1];
                assign w_data_in = w_data_all[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld  <= 1'b0;
                    r_data <= '0;
                end else if (i_flush) begin
                    r_vld  <= 1'b0;
                    r_data <= '0;
                end else begin
                    r_vld  <= w_vld_in;
                    r_data <= w_data_in;
                end
            end

            assign w_vld_all[gi]  = r_vld;
            assign w_data_all[gi] = r_data;
        end
    endgenerate

    assign o_valid     = w_vld_all[LAT-1];
    assign o_data      = w_data_all[LAT-1];
    assign o_any_valid = |w_vld_all;

endmodule

// File: rtl/adder_checker.sv
// Response checker for the adder: delays operands by the adder latency, compares
// sum/isOdd, counts checked and failing vectors and latches the first mismatch.
module adder_checker
    import adder_test_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int LAT   = 1,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    adder_checker_if.slave  bus
);
    localparam int PW = 1 + W + W + (W + 1);

    state_t           r_state;
    state_t           w_state_next;

    logic [W:0]       w_exp;
    logic             w_accept;
    logic [PW-1:0]    w_in_data;
    logic             w_out_valid;
    logic [PW-1:0]    w_out_data;
    logic             w_any_valid;
    logic             w_out_last;
    logic [W-1:0]     w_out_a;
    logic [W-1:0]     w_out_b;
    logic [W:0]       w_out_exp;
    logic             w_cmp;
    logic             w_mismatch;
    logic             w_drain_done;
    logic             w_capture;

    logic [CNT_W-1:0] r_check_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] w_check_next;
    logic [CNT_W-1:0] w_err_next;
    logic             r_done;
    logic             r_pass;
    logic [W-1:0]     r_first_a;
    logic [W-1:0]     r_first_b;
    logic [W:0]       r_first_got;
    logic [W:0]       r_first_exp;

    assign w_exp     = {1'b0, bus.inA} + {1'b0, bus.inB};
    // start wins over a coincident vector, so it never enters the pipe
    assign w_accept  = (r_state == RUN) && bus.valid && !bus.start;
    assign w_in_data = {bus.last, bus.inA, bus.inB, w_exp};

    adder_checker_delay #(
        .LAT (LAT),
        .PW  (PW)
    ) u_delay (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (bus.start),
        .i_valid     (w_accept),
        .i_data      (w_in_data),
        .o_valid     (w_out_valid),
        .o_data      (w_out_data),
        .o_any_valid (w_any_valid)
    );

    assign {w_out_last, w_out_a, w_out_b, w_out_exp} = w_out_data;

    // An aborting start discards the entry currently at the compare point too
    assign w_cmp        = w_out_valid && is_busy(r_state) && !bus.start;
    assign w_mismatch   = (bus.dutOut != w_out_exp) || (bus.dutIsOdd != w_out_exp[0]);
    assign w_drain_done = (w_cmp && w_out_last) || !w_any_valid;

    always_comb begin
        w_state_next = r_state;
        if (bus.start) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                RUN:     if (bus.valid && bus.last) w_state_next = DRAIN;
                DRAIN:   if (w_drain_done)          w_state_next = DONE;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_check_next = r_check_cnt;
        w_err_next   = r_err_cnt;
        w_capture    = 1'b0;
        if (bus.start) begin
            w_check_next = '0;
            w_err_next   = '0;
        end else if (w_cmp) begin
            if (r_check_cnt != '1) w_check_next = r_check_cnt + CNT_W'(1);
            if (w_mismatch) begin
                if (r_err_cnt != '1) w_err_next = r_err_cnt + CNT_W'(1);
                w_capture = (r_err_cnt == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_check_cnt <= '0;
            r_err_cnt   <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_first_a   <= '0;
            r_first_b   <= '0;
            r_first_got <= '0;
            r_first_exp <= '0;
        end else begin
            r_state     <= w_state_next;
            r_check_cnt <= w_check_next;
            r_err_cnt   <= w_err_next;
            r_done      <= (w_state_next == DONE);
            r_pass      <= (w_state_next == DONE) && (w_err_next == '0);
            if (bus.start) begin
                r_first_a   <= '0;
                r_first_b   <= '0;
                r_first_got <= '0;
                r_first_exp <= '0;
            end else if (w_capture) begin
                r_first_a   <= w_out_a;
                r_first_b   <= w_out_b;
                r_first_got <= bus.dutOut;
                r_first_exp <= w_out_exp;
            end
        end
    end

    assign bus.busy        = is_busy(r_state);
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.checkCount  = r_check_cnt;
    assign bus.errCount    = r_err_cnt;
    assign bus.firstErrA   = r_first_a;
    assign bus.firstErrB   = r_first_b;
    assign bus.firstErrGot = r_first_got;
    assign bus.firstErrExp = r_first_exp;

endmodule

// File: tb/tb_adder_checker.sv
// Bench for adder_checker: two instances (LAT=1 and LAT=3) fed the same stream,
// with bench-side adder models, a queue-based result model and per-cycle compare.
module tb_adder_checker;
    import adder_test_pkg::*;

    localparam int W     = 8;
    localparam int CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_checker_if #(.W(W), .CNT_W(CNT_W)) bus1 ();
    adder_checker_if #(.W(W), .CNT_W(CNT_W)) bus3 ();

    adder_checker #(.W(W), .LAT(1), .CNT_W(CNT_W)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    adder_checker #(.W(W), .LAT(3), .CNT_W(CNT_W)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int checks = 0;
    int errors = 0;

    // ---------------- adder models (stimulus side, with fault injection) ----
    int fault_mode = 0;

    function automatic logic [9:0] adder_fn(input logic [7:0] a, input logic [7:0] b, input int mode);
        logic [8:0] s;
        logic       odd;
        s   = {1'b0, a} + {1'b0, b};
        odd = s[0];
        if (mode == 1) begin
            if (a == 8'd5 && b == 8'd6) begin s = 9'd12; odd = 1'b0; end
            else if (a == 8'd1 && b == 8'd2) begin s = 9'd5; odd = 1'b0; end
        end else if (mode == 2) begin
            s[8] = 1'b0;
            odd  = s[0];
        end else if (mode == 3) begin
            if (((a ^ b) & 8'h07) == 8'h00) s = s ^ (9'd1 << (a % 9));
            odd = s[0];
        end
        return {odd, s};
    endfunction

    logic [9:0] p1;
    logic [9:0] p3 [3];
    always @(posedge clk) begin
        p1    <= adder_fn(bus1.inA, bus1.inB, fault_mode);
        p3[0] <= adder_fn(bus3.inA, bus3.inB, fault_mode);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus1.dutOut   = p1[8:0];
    assign bus1.dutIsOdd = p1[9];
    assign bus3.dutOut   = p3[2][8:0];
    assign bus3.dutIsOdd = p3[2][9];

    // ---------------- result model ----------------
    typedef struct {
        int         acc;   // clock edge that accepts the vector
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] got;
        logic       godd;
        logic       last;
    } vec_t;

    vec_t       vq[$];
    int         lat_of [2] = '{1, 3};
    int         nxt    [2] = '{0, 0};
    int         m_chk  [2] = '{0, 0};
    int         m_err  [2] = '{0, 0};
    bit         m_busy [2] = '{0, 0};
    bit         m_done [2] = '{0, 0};
    logic [7:0] m_fa   [2] = '{8'd0, 8'd0};
    logic [7:0] m_fb   [2] = '{8'd0, 8'd0};
    logic [8:0] m_fg   [2] = '{9'd0, 9'd0};
    logic [8:0] m_fe   [2] = '{9'd0, 9'd0};
    bit         clr_pend = 0;
    int         clr_due  = 0;
    int         clr_idx  = 0;
    bit         in_run   = 0;
    int         last_k   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear(input int d, input bit busy_after);
        m_chk[d]  = 0;
        m_err[d]  = 0;
        m_busy[d] = busy_after;
        m_done[d] = 0;
        m_fa[d]   = '0;
        m_fb[d]   = '0;
        m_fg[d]   = '0;
        m_fe[d]   = '0;
    endtask

    task automatic cmp_dut(input int d, input logic bz, input logic dn, input logic ps,
                           input logic [15:0] cc, input logic [15:0] ec,
                           input logic [7:0] fa, input logic [7:0] fb,
                           input logic [8:0] fg, input logic [8:0] fe);
        string p;
        p = (d == 0) ? "lat1" : "lat3";
        chk({p, ".busy"},        32'(bz), 32'(m_busy[d]));
        chk({p, ".done"},        32'(dn), 32'(m_done[d]));
        chk({p, ".pass"},        32'(ps), 32'(m_done[d] && (m_err[d] == 0)));
        chk({p, ".checkCount"},  32'(cc), 32'(m_chk[d]));
        chk({p, ".errCount"},    32'(ec), 32'(m_err[d]));
        chk({p, ".firstErrA"},   32'(fa), 32'(m_fa[d]));
        chk({p, ".firstErrB"},   32'(fb), 32'(m_fb[d]));
        chk({p, ".firstErrGot"}, 32'(fg), 32'(m_fg[d]));
        chk({p, ".firstErrExp"}, 32'(fe), 32'(m_fe[d]));
    endtask

    // A vector accepted at edge acc shows up in the counters LAT edges later.
    initial begin
        forever begin
            @(negedge clk);
            if (clr_pend && cyc >= clr_due) begin
                for (int d = 0; d < 2; d++) begin
                    nxt[d] = clr_idx;
                    model_clear(d, 1'b1);
                end
                clr_pend = 0;
            end
            for (int d = 0; d < 2; d++) begin
                while (nxt[d] < vq.size() && vq[nxt[d]].acc + lat_of[d] <= cyc) begin
                    int s;
                    bit bad;
                    s   = vq[nxt[d]].a + vq[nxt[d]].b;
                    bad = (int'(vq[nxt[d]].got) != s) || (vq[nxt[d]].godd != s[0]);
                    if (m_chk[d] < 65535) m_chk[d]++;
                    if (bad) begin
                        if (m_err[d] == 0) begin
                            m_fa[d] = vq[nxt[d]].a;
                            m_fb[d] = vq[nxt[d]].b;
                            m_fg[d] = vq[nxt[d]].got;
                            m_fe[d] = 9'(s);
                        end
                        if (m_err[d] < 65535) m_err[d]++;
                    end
                    if (vq[nxt[d]].last) begin
                        m_done[d] = 1;
                        m_busy[d] = 0;
                    end
                    nxt[d]++;
                end
            end
            cmp_dut(0, bus1.busy, bus1.done, bus1.pass, bus1.checkCount, bus1.errCount,
                    bus1.firstErrA, bus1.firstErrB, bus1.firstErrGot, bus1.firstErrExp);
            cmp_dut(1, bus3.busy, bus3.done, bus3.pass, bus3.checkCount, bus3.errCount,
                    bus3.firstErrA, bus3.firstErrB, bus3.firstErrGot, bus3.firstErrExp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit st, input bit v, input bit l, input logic [7:0] a, input logic [7:0] b);
        bus1.start = st; bus1.valid = v; bus1.last = l; bus1.inA = a; bus1.inB = b;
        bus3.start = st; bus3.valid = v; bus3.last = l; bus3.inA = a; bus3.inB = b;
    endtask

    task automatic drive(input bit st, input bit v, input bit l, input logic [7:0] a, input logic [7:0] b);
        set_in(st, v, l, a, b);
        if (st) begin
            clr_pend = 1;
            clr_due  = cyc + 1;
            clr_idx  = vq.size();
            in_run   = 1;
        end else if (v && in_run) begin
            vec_t e;
            e.acc = cyc + 1;
            e.a   = a;
            e.b   = b;
            {e.godd, e.got} = adder_fn(a, b, fault_mode);
            e.last = l;
            vq.push_back(e);
            $display("vec a=%0d b=%0d adder=%0d odd=%0d last=%0d", a, b, e.got, e.godd, l);
            if (l) begin
                in_run = 0;
                last_k = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic wait_done(input string name);
        int t1;
        int t3;
        t1 = -1;
        t3 = -1;
        set_in(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus1.done === 1'b1 && t1 < 0) t1 = cyc - last_k;
            if (bus3.done === 1'b1 && t3 < 0) t3 = cyc - last_k;
            @(posedge clk);
            #1;
        end
        chk({name, ".done_delay_lat1"}, 32'(t1), 32'd2);
        chk({name, ".done_delay_lat3"}, 32'(t3), 32'd4);
        $display("session %s: lat1 chk=%0d err=%0d pass=%0d | lat3 chk=%0d err=%0d pass=%0d",
                 name, bus1.checkCount, bus1.errCount, bus1.pass,
                 bus3.checkCount, bus3.errCount, bus3.pass);
    endtask

    task automatic assert_reset();
        rst_n    = 1'b0;
        vq.delete();
        nxt      = '{0, 0};
        clr_pend = 0;
        in_run   = 0;
        model_clear(0, 1'b0);
        model_clear(1, 1'b0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".lat1.outs"}, 32'({bus1.busy, bus1.done, bus1.pass}), 32'd0);
        chk({name, ".lat1.counts"}, {bus1.checkCount, bus1.errCount}, 32'd0);
        chk({name, ".lat1.first"}, 32'({bus1.firstErrA, bus1.firstErrB, bus1.firstErrGot, bus1.firstErrExp}), 32'd0);
        chk({name, ".lat3.outs"}, 32'({bus3.busy, bus3.done, bus3.pass}), 32'd0);
        chk({name, ".lat3.counts"}, {bus3.checkCount, bus3.errCount}, 32'd0);
        chk({name, ".lat3.first"}, 32'({bus3.firstErrA, bus3.firstErrB, bus3.firstErrGot, bus3.firstErrExp}), 32'd0);
    endtask

    task automatic run_list(input string name);
        logic [7:0] la [8];
        logic [7:0] lb [8];
        la = '{8'd0, 8'd1, 8'd5, 8'd2, 8'd3, 8'd1, 8'd1, 8'd3};
        lb = '{8'd0, 8'd1, 8'd6, 8'd2, 8'd3, 8'd8, 8'd2, 8'd4};
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, (i == 7), la[i], lb[i]);
        wait_done(name);
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        assert_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // valid while IDLE is ignored
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, i[0], 8'($urandom), 8'($urandom));
        chk("idle_valid.lat1.checkCount", 32'(bus1.checkCount), 32'd0);
        chk("idle_valid.lat3.checkCount", 32'(bus3.checkCount), 32'd0);

        // clean session
        fault_mode = 0;
        run_list("clean");
        chk("clean.lat1.checkCount", 32'(bus1.checkCount), 32'd8);
        chk("clean.lat1.errCount",   32'(bus1.errCount),   32'd0);
        chk("clean.lat1.pass",       32'(bus1.pass),       32'd1);
        chk("clean.lat3.checkCount", 32'(bus3.checkCount), 32'd8);
        chk("clean.lat3.pass",       32'(bus3.pass),       32'd1);

        // injected faults on (5,6) and (1,2)
        fault_mode = 1;
        run_list("fault");
        chk("fault.lat1.errCount",    32'(bus1.errCount),    32'd2);
        chk("fault.lat1.firstErrA",   32'(bus1.firstErrA),   32'd5);
        chk("fault.lat1.firstErrB",   32'(bus1.firstErrB),   32'd6);
        chk("fault.lat1.firstErrGot", 32'(bus1.firstErrGot), 32'd12);
        chk("fault.lat1.firstErrExp", 32'(bus1.firstErrExp), 32'd11);
        chk("fault.lat1.pass",        32'(bus1.pass),        32'd0);
        chk("fault.lat3.errCount",    32'(bus3.errCount),    32'd2);
        chk("fault.lat3.firstErrGot", 32'(bus3.firstErrGot), 32'd12);

        // valid while DONE is ignored
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 8'd7, 8'd7);
        chk("done_valid.lat1.checkCount", 32'(bus1.checkCount), 32'd8);
        chk("done_valid.lat1.errCount",   32'(bus1.errCount),   32'd2);

        // width edge with a truncating adder
        fault_mode = 2;
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 8'd255, 8'd255);
        drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd0);
        wait_done("width");
        chk("width.lat1.checkCount",  32'(bus1.checkCount),  32'd2);
        chk("width.lat1.errCount",    32'(bus1.errCount),    32'd1);
        chk("width.lat1.firstErrExp", 32'(bus1.firstErrExp), 32'd510);
        chk("width.lat1.firstErrGot", 32'(bus1.firstErrGot), 32'd254);
        chk("width.lat3.firstErrExp", 32'(bus3.firstErrExp), 32'd510);

        // abort mid-stream; restart coincides with a valid that must be dropped
        fault_mode = 0;
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 8'd10, 8'd20);
        drive(1'b0, 1'b1, 1'b0, 8'd30, 8'd40);
        drive(1'b0, 1'b1, 1'b0, 8'd50, 8'd60);
        drive(1'b1, 1'b1, 1'b0, 8'd9, 8'd9);
        drive(1'b0, 1'b0, 1'b1, 8'd1, 8'd1);
        drive(1'b0, 1'b1, 1'b0, 8'd100, 8'd27);
        drive(1'b0, 1'b1, 1'b1, 8'd128, 8'd128);
        wait_done("abort");
        chk("abort.lat1.checkCount", 32'(bus1.checkCount), 32'd2);
        chk("abort.lat3.checkCount", 32'(bus3.checkCount), 32'd2);

        // reset pulse while draining
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, (i == 3), 8'(i * 17), 8'(i * 3));
        assert_reset();
        #1;
        chk_all_zero("drain_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, (i == 2), 8'(200 + i), 8'(i));
        wait_done("after_reset");
        chk("after_reset.lat1.checkCount", 32'(bus1.checkCount), 32'd3);
        chk("after_reset.lat3.pass",       32'(bus3.pass),       32'd1);

        // randomized sessions
        for (int s = 0; s < 12; s++) begin
            int n;
            n = int'($urandom_range(3, 16));
            fault_mode = ($urandom_range(0, 1) == 1) ? 3 : 0;
            drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) idle();
                if ($urandom_range(0, 9) == 0) drive(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
                if (i == n / 2 && (s % 4) == 3) begin
                    drive(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
                    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
                end
                drive(1'b0, 1'b1, (i == n - 1), 8'($urandom), 8'($urandom));
            end
            wait_done("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
